// File: rtl/lift_request_scheduler.sv
// lift_request_scheduler: latches car/hall calls for a 3-floor lift and picks
// the next target floor with a SCAN policy (keep going while work lies ahead,
// then reverse). Served requests are retired from the lift's floor and door status.
module lift_request_scheduler #(
  parameter int DWELL_CYC = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       car_call,
  input  logic [1:0]       hall_up,
  input  logic [1:0]       hall_dn,
  input  logic [1:0]       cur_flr,
  input  logic             door,
  output logic [1:0]       flr_sel,
  output logic [1:0]       dir,
  output logic [2:0]       car_pend,
  output logic [1:0]       up_pend,
  output logic [1:0]       dn_pend,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_ARRIVE,
    S_DWELL
  } state_t;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  // DWELL_CYC of 0 is not a legal configuration; the counter ends one early.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

  state_t           state, state_next;
  logic [1:0]       pos;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       flr_sel_next, dir_next;
  logic [2:0]       car_clr;
  logic [1:0]       up_clr, dn_clr;

  // Per-floor request views: bit i = floor i+1.
  logic [2:0]       req_any, req_up, req_dn;
  logic [2:0]       pos_hot, above, below;
  logic [2:0]       up_first, up_any, dn_first, dn_any;
  logic             req_here, req_above, req_below;
  logic [1:0]       up_tgt, dn_tgt;
  logic             going_dn, ahead, behind;

  // Request views and SCAN target selection relative to the current floor.
  always_comb begin
    req_any = car_pend | {1'b0, up_pend} | {dn_pend, 1'b0};
    req_up  = car_pend | {1'b0, up_pend};
    req_dn  = car_pend | {dn_pend, 1'b0};

    pos_hot = 3'b000;
    above   = 3'b000;
    below   = 3'b000;
    case (pos)
      2'd1: begin pos_hot = 3'b001; above = 3'b110; end
      2'd2: begin pos_hot = 3'b010; above = 3'b100; below = 3'b001; end
      2'd3: begin pos_hot = 3'b100; below = 3'b011; end
      default: ;
    endcase

    req_here  = |(req_any & pos_hot);
    req_above = |(req_any & above);
    req_below = |(req_any & below);

    up_first = req_up & above;
    up_any   = req_any & above;
    if (up_first[1])     up_tgt = 2'd2;
    else if (up_first[2]) up_tgt = 2'd3;
    else if (up_any[2])   up_tgt = 2'd3;
    else if (up_any[1])   up_tgt = 2'd2;
    else                  up_tgt = 2'd0;

    dn_first = req_dn & below;
    dn_any   = req_any & below;
    if (dn_first[1])     dn_tgt = 2'd2;
    else if (dn_first[0]) dn_tgt = 2'd1;
    else if (dn_any[0])   dn_tgt = 2'd1;
    else if (dn_any[1])   dn_tgt = 2'd2;
    else                  dn_tgt = 2'd0;

    going_dn = (dir == DIR_DN);
    ahead    = going_dn ? req_below : req_above;
    behind   = going_dn ? req_above : req_below;
  end

  // Next-state, next-output and request-clear decisions for the scheduler FSM.
  always_comb begin
    state_next   = state;
    flr_sel_next = flr_sel;
    dir_next     = dir;
    cnt_next     = cnt;
    car_clr      = 3'b000;
    up_clr       = 2'b00;
    dn_clr       = 2'b00;

    case (state)
      S_IDLE: begin
        if (req_here) begin
          state_next   = S_ARRIVE;
          flr_sel_next = pos;
          dir_next     = DIR_IDLE;
        end else if (req_above) begin
          state_next   = S_UP;
          flr_sel_next = up_tgt;
          dir_next     = DIR_UP;
        end else if (req_below) begin
          state_next   = S_DOWN;
          flr_sel_next = dn_tgt;
          dir_next     = DIR_DN;
        end
      end

      S_UP: begin
        if (pos == flr_sel) begin
          if (door) state_next = S_ARRIVE;
        end else if (up_tgt == 2'd0) begin
          state_next   = S_IDLE;
          flr_sel_next = 2'd0;
          dir_next     = DIR_IDLE;
        end else begin
          flr_sel_next = up_tgt;
        end
      end

      S_DOWN: begin
        if (pos == flr_sel) begin
          if (door) state_next = S_ARRIVE;
        end else if (dn_tgt == 2'd0) begin
          state_next   = S_IDLE;
          flr_sel_next = 2'd0;
          dir_next     = DIR_IDLE;
        end else begin
          flr_sel_next = dn_tgt;
        end
      end

      S_ARRIVE: begin
        car_clr = pos_hot;
        if (dir != DIR_DN || pos == 2'd1) up_clr = pos_hot[1:0];
        if (dir != DIR_UP || pos == 2'd3) dn_clr = pos_hot[2:1];
        flr_sel_next = 2'd0;
        cnt_next     = '0;
        state_next   = S_DWELL;
      end

      S_DWELL: begin
        if (door) begin
          cnt_next = '0;
        end else if (cnt != DWELL_LAST) begin
          cnt_next = cnt + 1'b1;
        end else begin
          cnt_next = '0;
          if (ahead) begin
            state_next   = going_dn ? S_DOWN : S_UP;
            flr_sel_next = going_dn ? dn_tgt : up_tgt;
            dir_next     = going_dn ? DIR_DN : DIR_UP;
          end else if (behind) begin
            state_next   = going_dn ? S_UP : S_DOWN;
            flr_sel_next = going_dn ? up_tgt : dn_tgt;
            dir_next     = going_dn ? DIR_UP : DIR_DN;
          end else if (req_here) begin
            state_next   = S_ARRIVE;
            flr_sel_next = pos;
            dir_next     = DIR_IDLE;
          end else begin
            state_next   = S_IDLE;
            flr_sel_next = 2'd0;
            dir_next     = DIR_IDLE;
          end
        end
      end

      default: begin
        state_next   = S_IDLE;
        flr_sel_next = 2'd0;
        dir_next     = DIR_IDLE;
        cnt_next     = '0;
      end
    endcase
  end

  // FSM state, registered lift-facing outputs and dwell counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      flr_sel <= 2'd0;
      dir     <= DIR_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      flr_sel <= flr_sel_next;
      dir     <= dir_next;
      cnt     <= cnt_next;
      busy    <= (state_next != S_IDLE);
    end
  end

  // Request latches (a served clear beats a same-cycle press) and floor tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      car_pend <= 3'b000;
      up_pend  <= 2'b00;
      dn_pend  <= 2'b00;
      pos      <= 2'd1;
    end else begin
      car_pend <= (car_pend | car_call) & ~car_clr;
      up_pend  <= (up_pend | hall_up) & ~up_clr;
      dn_pend  <= (dn_pend | hall_dn) & ~dn_clr;
      if (cur_flr != 2'd0) pos <= cur_flr;
    end
  end

endmodule

// File: tb/tb_lift_request_scheduler.sv
// tb_lift_request_scheduler: random and directed button traffic against a
// floor-level reference model, with a simple lift model closing the loop.
module tb_lift_request_scheduler;

  localparam int DWELL_CYC = 4;

  localparam int M_IDLE   = 0;
  localparam int M_UP     = 1;
  localparam int M_DOWN   = 2;
  localparam int M_ARRIVE = 3;
  localparam int M_DWELL  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] car_call = 3'b000;
  logic [1:0] hall_up = 2'b00;
  logic [1:0] hall_dn = 2'b00;
  logic [1:0] cur_flr = 2'b00;
  logic       door = 1'b0;
  logic [1:0] flr_sel, dir;
  logic [2:0] car_pend;
  logic [1:0] up_pend, dn_pend;
  logic       busy;

  lift_request_scheduler #(.DWELL_CYC(DWELL_CYC), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .car_call (car_call),
    .hall_up  (hall_up),
    .hall_dn  (hall_dn),
    .cur_flr  (cur_flr),
    .door     (door),
    .flr_sel  (flr_sel),
    .dir      (dir),
    .car_pend (car_pend),
    .up_pend  (up_pend),
    .dn_pend  (dn_pend),
    .busy     (busy)
  );

  typedef struct packed {
    logic [1:0] flr_sel;
    logic [1:0] dir;
    logic [2:0] car_pend;
    logic [1:0] up_pend;
    logic [1:0] dn_pend;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   mid_dwell_resets = 0;

  // Reference model: floors 1..3, one flag per floor and call type.
  int m_mode = M_IDLE, m_pos = 1, m_sel = 0, m_dir = 0, m_dwell = 0;
  bit m_busy = 0;
  bit m_car[1:3], m_up[1:3], m_dn[1:3];

  // Lift model: physical floor, door and travel timers.
  int lf = 1, lmove = 3, ltimer = 0, lreport = 0;
  bit ldoor = 0;

  always #5 clk = ~clk;

  function automatic bit anyReq(int f);
    return m_car[f] | m_up[f] | m_dn[f];
  endfunction

  function automatic bit reqAbove();
    for (int f = m_pos + 1; f <= 3; f++) if (anyReq(f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit reqBelow();
    for (int f = 1; f < m_pos; f++) if (anyReq(f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit anyPending();
    for (int f = 1; f <= 3; f++) if (anyReq(f)) return 1'b1;
    return 1'b0;
  endfunction

  // Nearest floor above wanting to go up (or car), else the farthest floor above with anything.
  function automatic int upTarget();
    for (int f = m_pos + 1; f <= 3; f++) if (m_car[f] || m_up[f]) return f;
    for (int f = 3; f > m_pos; f--) if (anyReq(f)) return f;
    return 0;
  endfunction

  function automatic int downTarget();
    for (int f = m_pos - 1; f >= 1; f--) if (m_car[f] || m_dn[f]) return f;
    for (int f = 1; f < m_pos; f++) if (anyReq(f)) return f;
    return 0;
  endfunction

  task automatic modelStep(input logic [2:0] car, input logic [1:0] hu, input logic [1:0] hd,
                           input logic rst, input logic [1:0] cf, input logic dr);
    int nmode, nsel, ndir, ndwell;
    bit ncar[1:3], nup[1:3], ndn[1:3];
    if (rst) begin
      for (int f = 1; f <= 3; f++) begin m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0; end
      m_mode = M_IDLE; m_pos = 1; m_sel = 0; m_dir = 0; m_dwell = 0; m_busy = 0;
      return;
    end
    nmode = m_mode; nsel = m_sel; ndir = m_dir; ndwell = m_dwell;
    for (int f = 1; f <= 3; f++) begin ncar[f] = m_car[f] | car[f-1]; nup[f] = m_up[f]; ndn[f] = m_dn[f]; end
    if (hu[0]) nup[1] = 1;
    if (hu[1]) nup[2] = 1;
    if (hd[0]) ndn[2] = 1;
    if (hd[1]) ndn[3] = 1;
    case (m_mode)
      M_IDLE: begin
        if (anyReq(m_pos)) begin nmode = M_ARRIVE; nsel = m_pos; ndir = 0; end
        else if (reqAbove()) begin nmode = M_UP; nsel = upTarget(); ndir = 1; end
        else if (reqBelow()) begin nmode = M_DOWN; nsel = downTarget(); ndir = 2; end
      end
      M_UP, M_DOWN: begin
        if (m_sel == m_pos) begin
          if (dr) nmode = M_ARRIVE;
        end else begin
          nsel = (m_mode == M_UP) ? upTarget() : downTarget();
          if (nsel == 0) begin nmode = M_IDLE; ndir = 0; end
        end
      end
      M_ARRIVE: begin
        ncar[m_pos] = 0;
        // the up call at this floor is served heading up/idle, or at the bottom
        if (m_dir == 0 || m_dir == 1 || m_pos == 1) nup[m_pos] = 0;
        if (m_dir == 0 || m_dir == 2 || m_pos == 3) ndn[m_pos] = 0;
        nsel = 0; nmode = M_DWELL; ndwell = 0;
      end
      M_DWELL: begin
        if (dr) ndwell = 0;
        else if (m_dwell < DWELL_CYC - 1) ndwell = m_dwell + 1;
        else begin
          bit want_up_first;
          ndwell = 0;
          want_up_first = (m_dir != 2);
          if (want_up_first ? reqAbove() : reqBelow()) begin
            nmode = want_up_first ? M_UP : M_DOWN;
            nsel  = want_up_first ? upTarget() : downTarget();
            ndir  = want_up_first ? 1 : 2;
          end else if (want_up_first ? reqBelow() : reqAbove()) begin
            nmode = want_up_first ? M_DOWN : M_UP;
            nsel  = want_up_first ? downTarget() : upTarget();
            ndir  = want_up_first ? 2 : 1;
          end else if (anyReq(m_pos)) begin
            nmode = M_ARRIVE; nsel = m_pos; ndir = 0;
          end else begin
            nmode = M_IDLE; nsel = 0; ndir = 0;
          end
        end
      end
      default: ;
    endcase
    for (int f = 1; f <= 3; f++) begin m_car[f] = ncar[f]; m_up[f] = nup[f]; m_dn[f] = ndn[f]; end
    m_up[3] = 0; m_dn[1] = 0;
    m_mode = nmode; m_sel = nsel; m_dir = ndir; m_dwell = ndwell;
    m_busy = (nmode != M_IDLE);
    if (cf != 2'd0) m_pos = int'(cf);
  endtask

  task automatic liftStep(output logic [1:0] cf, output logic dr);
    cf = 2'd0;
    if (lreport > 0) begin
      lreport--;
      if (lreport == 0) cf = 2'(lf);
    end
    if (ldoor) begin
      if (ltimer > 0) ltimer--;
      else ldoor = 0;
    end else if (m_sel != 0 && m_sel != lf) begin
      if (lmove > 0) lmove--;
      else begin
        lf = (m_sel > lf) ? lf + 1 : lf - 1;
        cf = 2'(lf);
        lmove = $urandom_range(1, 3);
      end
    end else begin
      lmove = 3;
      if (m_sel != 0 && m_sel == lf) begin
        ldoor = 1;
        ltimer = $urandom_range(1, 4);
      end
    end
    dr = ldoor;
  endtask

  task automatic applyStimulus(input logic [2:0] car, input logic [1:0] hu,
                               input logic [1:0] hd, input logic rst);
    logic [1:0] cf;
    logic       dr;
    exp_t       e;
    @(negedge clk);
    liftStep(cf, dr);
    if (rst) lreport = 4;
    car_call = car; hall_up = hu; hall_dn = hd; reset = rst; cur_flr = cf; door = dr;
    modelStep(car, hu, hd, rst, cf, dr);
    e.flr_sel  = 2'(m_sel);
    e.dir      = 2'(m_dir);
    e.car_pend = {m_car[3], m_car[2], m_car[1]};
    e.up_pend  = {m_up[2], m_up[1]};
    e.dn_pend  = {m_dn[3], m_dn[2]};
    e.busy     = m_busy;
    exp_q.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("flr_sel",  8'(flr_sel),  8'(e.flr_sel));
    checkField("dir",      8'(dir),      8'(e.dir));
    checkField("car_pend", 8'(car_pend), 8'(e.car_pend));
    checkField("up_pend",  8'(up_pend),  8'(e.up_pend));
    checkField("dn_pend",  8'(dn_pend),  8'(e.dn_pend));
    checkField("busy",     8'(busy),     8'(e.busy));
  endtask

  task automatic waitIdle(input int max_cycles);
    int n = 0;
    do begin
      applyStimulus(3'b000, 2'b00, 2'b00, 1'b0);
      n++;
    end while (!(m_mode == M_IDLE && !ldoor) && n < max_cycles);
    tests_run++;
    if (!(m_mode == M_IDLE && !ldoor)) begin
      tests_failed++;
      $display("[TB] FAIL waitIdle: still busy after %0d cycles, expected idle", n);
    end
  endtask

  // Monitor: one expected snapshot per clock edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  // Stimulus: reset, the directed scenarios, then randomized traffic.
  initial begin
    logic [2:0] car;
    logic [1:0] hu, hd;
    logic       rst;

    for (int f = 1; f <= 3; f++) begin m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0; end
    applyStimulus(3'b000, 2'b00, 2'b00, 1'b1);
    applyStimulus(3'b000, 2'b00, 2'b00, 1'b1);
    lreport = 0;

    // floor 1 -> 3 on a single car pulse, then dwell and idle
    applyStimulus(3'b100, 2'b00, 2'b00, 1'b0);
    waitIdle(200);

    // idle at floor 2, then simultaneous calls for 1 and 3: up wins
    applyStimulus(3'b010, 2'b00, 2'b00, 1'b0);
    waitIdle(200);
    applyStimulus(3'b101, 2'b00, 2'b00, 1'b0);
    waitIdle(400);

    // from floor 1 toward 3, a floor-2 up call retargets the lift
    applyStimulus(3'b001, 2'b00, 2'b00, 1'b0);
    waitIdle(200);
    applyStimulus(3'b100, 2'b00, 2'b00, 1'b0);
    applyStimulus(3'b000, 2'b00, 2'b00, 1'b0);
    applyStimulus(3'b000, 2'b10, 2'b00, 1'b0);
    waitIdle(400);

    // press the served car button during ARRIVE (ignored) and just after (kept)
    applyStimulus(3'b100, 2'b00, 2'b00, 1'b0);
    applyStimulus(3'b000, 2'b00, 2'b00, 1'b0);
    applyStimulus(3'b100, 2'b00, 2'b00, 1'b0);
    applyStimulus(3'b100, 2'b00, 2'b00, 1'b0);
    waitIdle(200);

    for (int i = 0; i < 3000; i++) begin
      car = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      hu  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hd  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (m_mode == M_ARRIVE && $urandom_range(0, 1) == 1) begin
        car = car | 3'(1 << (m_pos - 1));
        hu  = 2'($urandom_range(0, 3));
        hd  = 2'($urandom_range(0, 3));
      end
      rst = (m_mode == M_DWELL && anyPending() && $urandom_range(0, 24) == 0);
      if (rst) mid_dwell_resets++;
      applyStimulus(car, hu, hd, rst);
    end
    waitIdle(600);
    applyStimulus(3'b000, 2'b00, 2'b00, 1'b0);
    @(posedge clk);
    #2;
    $display("[TB] mid-dwell resets issued: %0d", mid_dwell_resets);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
